// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, ASCII constants and parameter defaults for the Morse decoder
package morse_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  localparam logic [7:0] ASCII_Q = 8'h3F;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam int DASH_DEF = 3;
  localparam int GAP_DEF = 3;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/morse_lut.sv
// morse_lut: combinational decode of symbol count and pattern (first symbol most significant, dash=1) to ASCII
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] sym_count,
  input  logic [4:0] pattern,
  output logic [7:0] ascii,
  output logic       error
);
  logic [4:0] p;
  logic [7:0] k;
  always_comb begin
    p = pattern & ((5'd1 << sym_count) - 5'd1);
    k = {sym_count, p};
    ascii = ASCII_Q;
    case (k)
      {3'd1, 5'b00000}: ascii = ASCII_A + 8'd4;
      {3'd1, 5'b00001}: ascii = ASCII_A + 8'd19;
      {3'd2, 5'b00000}: ascii = ASCII_A + 8'd8;
      {3'd2, 5'b00001}: ascii = ASCII_A + 8'd0;
      {3'd2, 5'b00010}: ascii = ASCII_A + 8'd13;
      {3'd2, 5'b00011}: ascii = ASCII_A + 8'd12;
      {3'd3, 5'b00000}: ascii = ASCII_A + 8'd18;
      {3'd3, 5'b00001}: ascii = ASCII_A + 8'd20;
      {3'd3, 5'b00010}: ascii = ASCII_A + 8'd17;
      {3'd3, 5'b00011}: ascii = ASCII_A + 8'd22;
      {3'd3, 5'b00100}: ascii = ASCII_A + 8'd3;
      {3'd3, 5'b00101}: ascii = ASCII_A + 8'd10;
      {3'd3, 5'b00110}: ascii = ASCII_A + 8'd6;
      {3'd3, 5'b00111}: ascii = ASCII_A + 8'd14;
      {3'd4, 5'b00000}: ascii = ASCII_A + 8'd7;
      {3'd4, 5'b00001}: ascii = ASCII_A + 8'd21;
      {3'd4, 5'b00010}: ascii = ASCII_A + 8'd5;
      {3'd4, 5'b00100}: ascii = ASCII_A + 8'd11;
      {3'd4, 5'b00110}: ascii = ASCII_A + 8'd15;
      {3'd4, 5'b00111}: ascii = ASCII_A + 8'd9;
      {3'd4, 5'b01000}: ascii = ASCII_A + 8'd1;
      {3'd4, 5'b01001}: ascii = ASCII_A + 8'd23;
      {3'd4, 5'b01010}: ascii = ASCII_A + 8'd2;
      {3'd4, 5'b01011}: ascii = ASCII_A + 8'd24;
      {3'd4, 5'b01100}: ascii = ASCII_A + 8'd25;
      {3'd4, 5'b01101}: ascii = ASCII_A + 8'd16;
      {3'd5, 5'b11111}: ascii = ASCII_0 + 8'd0;
      {3'd5, 5'b01111}: ascii = ASCII_0 + 8'd1;
      {3'd5, 5'b00111}: ascii = ASCII_0 + 8'd2;
      {3'd5, 5'b00011}: ascii = ASCII_0 + 8'd3;
      {3'd5, 5'b00001}: ascii = ASCII_0 + 8'd4;
      {3'd5, 5'b00000}: ascii = ASCII_0 + 8'd5;
      {3'd5, 5'b10000}: ascii = ASCII_0 + 8'd6;
      {3'd5, 5'b11000}: ascii = ASCII_0 + 8'd7;
      {3'd5, 5'b11100}: ascii = ASCII_0 + 8'd8;
      {3'd5, 5'b11110}: ascii = ASCII_0 + 8'd9;
      default: ascii = ASCII_Q;
    endcase
    error = ascii == ASCII_Q;
  end
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: tick-timed Morse key FSM collecting dots/dashes into letters, with idle timeout
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DASH_TICKS = DASH_DEF,
  parameter int GAP_TICKS = GAP_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key,
  output logic [7:0] ascii,
  output logic       letter_valid,
  output logic       timeout,
  output logic       error,
  output logic [2:0] sym_count,
  output logic       busy
);
  localparam logic [3:0] DASH = 4'(DASH_TICKS);
  localparam logic [3:0] GAPL = 4'(GAP_TICKS);
  localparam logic [4:0] TMO = 5'(TIMEOUT_TICKS);
  state_t state, nxt;
  logic [3:0] press_cnt, gap_cnt;
  logic [4:0] idle_cnt, pattern;
  logic armed, emit, lut_err;
  logic [7:0] lut_ascii;
  morse_lut u_lut (.sym_count(sym_count), .pattern(pattern), .ascii(lut_ascii), .error(lut_err));
  assign emit = state == GAP && !key && tick && gap_cnt + 4'd1 >= GAPL;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb nxt = key ? PRESS : state == PRESS ? GAP : emit ? IDLE : state;
  always_comb busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt <= '0;
      gap_cnt <= '0;
      idle_cnt <= '0;
      pattern <= '0;
      sym_count <= '0;
      armed <= 1'b1;
      ascii <= '0;
      error <= 1'b0;
      letter_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      letter_valid <= emit;
      timeout <= 1'b0;
      if (key) begin
        armed <= 1'b1;
        idle_cnt <= '0;
      end
      if (key && state != PRESS) press_cnt <= {3'b0, tick};
      else if (state == PRESS && key && tick && press_cnt != 4'd15) press_cnt <= press_cnt + 4'd1;
      if (state == PRESS && !key) begin
        pattern <= {pattern[3:0], press_cnt >= DASH};
        sym_count <= sym_count == 3'd6 ? 3'd6 : sym_count + 3'd1;
        gap_cnt <= {3'b0, tick};
      end else if (state == GAP && !key && tick) gap_cnt <= gap_cnt + 4'd1;
      if (emit) begin
        ascii <= lut_ascii;
        error <= lut_err;
        pattern <= '0;
        sym_count <= '0;
      end
      if (state == IDLE && !key && tick && armed) begin
        idle_cnt <= idle_cnt + 5'd1;
        if (idle_cnt + 5'd1 == TMO) begin
          timeout <= 1'b1;
          armed <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed self-checking bench for morse_decoder with default timing parameters
module tb_morse_decoder;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, key = 1'b0;
  logic [7:0] ascii;
  logic letter_valid, timeout, error, busy;
  logic [2:0] sym_count;
  int total = 0, bad = 0, lv_cnt = 0, to_cnt = 0;
  morse_decoder dut (
    .clk(clk), .rst(rst), .tick(tick), .key(key), .ascii(ascii),
    .letter_valid(letter_valid), .timeout(timeout), .error(error),
    .sym_count(sym_count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(negedge clk);
    lv_cnt += int'(letter_valid);
    to_cnt += int'(timeout);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask
  task automatic press(input int n);
    key = 1'b1;
    cyc();
    ticks(n);
    key = 1'b0;
    cyc();
  endtask
  task automatic syms(input string s, input int dl);
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) ticks(1);
      press(s[i] == 8'h2D ? dl : 1);
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic letter(input string tag, input string s, input int dl, input logic [7:0] ch, input logic err);
    lv_cnt = 0;
    syms(s, dl);
    ticks(2);
    chk({tag, "_early"}, 8'(lv_cnt), 8'd0);
    ticks(1);
    chk({tag, "_lv"}, 8'(lv_cnt), 8'd1);
    chk({tag, "_ascii"}, ascii, ch);
    chk({tag, "_err"}, {7'b0, error}, {7'b0, err});
    chk({tag, "_cnt"}, {5'b0, sym_count}, 8'd0);
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_ascii", ascii, 8'h00);
    chk("rst_lv", {7'b0, letter_valid}, 8'd0);
    chk("rst_to", {7'b0, timeout}, 8'd0);
    chk("rst_err", {7'b0, error}, 8'd0);
    chk("rst_cnt", {5'b0, sym_count}, 8'd0);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    rst = 1'b0;
    lv_cnt = 0;
    to_cnt = 0;
    ticks(14);
    chk("to_early", 8'(to_cnt), 8'd0);
    ticks(1);
    chk("to_pulse", 8'(to_cnt), 8'd1);
    ticks(20);
    chk("to_once", 8'(to_cnt), 8'd1);
    press(1);
    chk("a_busy", {7'b0, busy}, 8'd1);
    chk("a_cnt1", {5'b0, sym_count}, 8'd1);
    ticks(1);
    press(3);
    chk("a_cnt2", {5'b0, sym_count}, 8'd2);
    lv_cnt = 0;
    ticks(2);
    chk("a_early", 8'(lv_cnt), 8'd0);
    ticks(1);
    chk("a_lv", 8'(lv_cnt), 8'd1);
    chk("a_ascii", ascii, 8'h41);
    chk("a_err", {7'b0, error}, 8'd0);
    chk("a_busy_end", {7'b0, busy}, 8'd0);
    to_cnt = 0;
    ticks(14);
    chk("rearm_early", 8'(to_cnt), 8'd0);
    ticks(1);
    chk("rearm_pulse", 8'(to_cnt), 8'd1);
    to_cnt = 0;
    letter("zero", "-----", 4, 8'h30, 1'b0);
    syms("......", 3);
    chk("six_cnt", {5'b0, sym_count}, 8'd6);
    ticks(1);
    press(1);
    chk("sat_cnt", {5'b0, sym_count}, 8'd6);
    lv_cnt = 0;
    ticks(3);
    chk("six_lv", 8'(lv_cnt), 8'd1);
    chk("six_ascii", ascii, 8'h3F);
    chk("six_err", {7'b0, error}, 8'd1);
    letter("bad4", "..--", 3, 8'h3F, 1'b1);
    letter("k", "-.-", 3, 8'h4B, 1'b0);
    letter("seven", "--...", 3, 8'h37, 1'b0);
    letter("long", "-", 20, 8'h54, 1'b0);
    chk("no_to_busy", 8'(to_cnt), 8'd0);
    lv_cnt = 0;
    press(1);
    ticks(2);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    key = 1'b1;
    chk("ovl_e", ascii, 8'h45);
    cyc();
    ticks(3);
    key = 1'b0;
    cyc();
    ticks(3);
    chk("ovl_lv", 8'(lv_cnt), 8'd2);
    chk("ovl_t", ascii, 8'h54);
    syms("..", 3);
    key = 1'b1;
    cyc();
    ticks(1);
    lv_cnt = 0;
    rst = 1'b1;
    key = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("mid_ascii", ascii, 8'h00);
    chk("mid_cnt", {5'b0, sym_count}, 8'd0);
    chk("mid_busy", {7'b0, busy}, 8'd0);
    chk("mid_lv", 8'(lv_cnt), 8'd0);
    letter("after_rst", ".", 3, 8'h45, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
